// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter:
// grant-state encoding, requester IDs and default line size.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } gnt_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/mem_port_arbiter_beat.sv
// Per-line beat tracker: critical-word-first offset that wraps
// inside the line, beat count and last-beat flag.
module line_beat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int OFFSET_W   = $clog2(LINE_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load,
    input  logic [OFFSET_W-1:0] load_offset,
    input  logic                beat,
    output logic [OFFSET_W-1:0] offset,
    output logic                last
);

    logic [OFFSET_W-1:0] count_q;
    logic [OFFSET_W-1:0] offset_q;

    // Load the start word on grant, then advance once per accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            offset_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            offset_q <= load_offset;
            count_q  <= '0;
        end else if (beat) begin
            offset_q <= offset_q + 1'b1;
            count_q  <= count_q + 1'b1;
        end
    end

    assign offset = offset_q;
    assign last   = (count_q == OFFSET_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache
// refill path and the D-cache refill/write-back path.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:2] i_addr_i,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    output logic        i_done_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:2] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_wnext_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:2] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int BASE_W   = 30 - OFFSET_W;

    gnt_state_e          state_q, state_d;
    req_id_e             last_grant_q;
    logic [BASE_W-1:0]   base_q;
    logic                we_q;
    logic                grant_i, grant_d;
    logic                busy, beat, last;
    logic                want_i, want_d;
    logic [OFFSET_W-1:0] offset;
    logic [OFFSET_W-1:0] load_offset;
    logic                i_rvalid_q, d_rvalid_q;
    logic                i_done_q, d_done_q;
    logic [31:0]         i_rdata_q, d_rdata_q;

    assign busy = (state_q != IDLE);
    assign beat = busy & mem_ack_i;

    // A side still seeing its done pulse is finishing, not asking again.
    assign want_i = i_req_i & ~i_done_q;
    assign want_d = d_req_i & ~d_done_q;

    assign load_offset = grant_d ? d_addr_i[OFFSET_W+1:2]
                                 : i_addr_i[OFFSET_W+1:2];

    // Arbitrate in IDLE; return to IDLE after the last beat.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (want_i && (!want_d || last_grant_q == REQ_D)) begin
                    grant_i = 1'b1;
                    state_d = GNT_I;
                end else if (want_d) begin
                    grant_d = 1'b1;
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (beat && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus per-grant latches of line base, direction, owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_D;
            base_q       <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_i || grant_d) begin
                base_q       <= grant_d ? d_addr_i[31:OFFSET_W+2]
                                        : i_addr_i[31:OFFSET_W+2];
                we_q         <= grant_d & d_we_i;
                last_grant_q <= grant_d ? REQ_D : REQ_I;
            end
        end
    end

    line_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (grant_i | grant_d),
        .load_offset (load_offset),
        .beat        (beat),
        .offset      (offset),
        .last        (last)
    );

    // Register read beats and the completion pulse toward the owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= beat & ~we_q & (state_q == GNT_I);
            d_rvalid_q <= beat & ~we_q & (state_q == GNT_D);
            i_done_q   <= beat & last & (state_q == GNT_I);
            d_done_q   <= beat & last & (state_q == GNT_D);
            if (beat && !we_q && state_q == GNT_I) i_rdata_q <= mem_rdata_i;
            if (beat && !we_q && state_q == GNT_D) d_rdata_q <= mem_rdata_i;
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = busy & we_q;
    assign mem_addr_o  = {base_q, offset};
    assign mem_wdata_o = d_wdata_i;
    assign d_wnext_o   = beat & we_q & (state_q == GNT_D);
    assign i_rvalid_o  = i_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign i_done_o    = i_done_q;
    assign d_done_o    = d_done_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: line-level model plus
// directed scenarios, and a LINE_WORDS=8 instance for wrap checks.
module tb_mem_port_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [29:0] i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;

    always #5 clk = ~clk;

    assign mem_rdata = {mem_addr, 2'b00} ^ 32'h5A5A_0000;

    mem_port_arbiter #(.LINE_WORDS(LW)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(i_req), .i_addr_i(i_addr),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_done_o(i_done),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_wnext_o(d_wnext),
        .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_done_o(d_done),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    logic        i_req8 = 1'b0, ack8 = 1'b0;
    logic [29:0] i_addr8 = '0;
    logic        i_rv8, i_dn8, d_wn8, d_rv8, d_dn8, mreq8, mwe8;
    logic [31:0] i_rd8, d_rd8, mwd8;
    logic [29:0] maddr8;

    mem_port_arbiter #(.LINE_WORDS(8)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(i_req8), .i_addr_i(i_addr8),
        .i_rvalid_o(i_rv8), .i_rdata_o(i_rd8), .i_done_o(i_dn8),
        .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(30'd0),
        .d_wdata_i(32'd0), .d_wnext_o(d_wn8),
        .d_rvalid_o(d_rv8), .d_rdata_o(d_rd8), .d_done_o(d_dn8),
        .mem_req_o(mreq8), .mem_we_o(mwe8), .mem_addr_o(maddr8),
        .mem_wdata_o(mwd8), .mem_ack_i(ack8),
        .mem_rdata_i(32'h1234_5678)
    );

    int checks = 0, passes = 0;

    // Line-level model: owner (0 none, 1 I, 2 D), beats done, line, start.
    int          m_side = 0, m_last = 2, m_n = 0, m_start = 0;
    logic [29:0] m_line = '0;
    bit          m_we = 0;
    bit          e_irv = 0, e_drv = 0, e_idn = 0, e_ddn = 0;
    logic [31:0] e_ird = '0, e_drd = '0;

    bit i_pend = 0, d_pend = 0, rst_v = 1;
    int ack_mode = 0, stall_left = 0, cyc_n = 0;
    int n_wnext, n_irv, n_drv, n_idone, n_ddone, n_req;
    int last_irv_c, idone_c, last_wn_c, ddone_c;
    logic [29:0] alog[$];
    int glog[$];
    int olog[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [29:0] exp_addr();
        return m_line + 30'((m_start + m_n) % LW);
    endfunction

    task automatic clr();
        n_wnext = 0; n_irv = 0; n_drv = 0; n_idone = 0; n_ddone = 0;
        n_req = 0; last_irv_c = -1; idone_c = -2;
        last_wn_c = -1; ddone_c = -2;
        alog.delete(); glog.delete(); olog.delete();
    endtask

    task automatic compare();
        bit exp_wn;
        exp_wn = (m_side == 2) && m_we && mem_ack;
        chk("mem_req", mem_req, m_side != 0);
        chk("mem_we", mem_we, (m_side != 0) && m_we);
        if (m_side != 0) chk("mem_addr", mem_addr, exp_addr());
        chk("d_wnext", d_wnext, exp_wn);
        if (exp_wn) chk("mem_wdata", mem_wdata, d_wdata);
        chk("i_rvalid", i_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("i_done", i_done, e_idn);
        chk("d_done", d_done, e_ddn);
        if (e_irv) chk("i_rdata", i_rdata, e_ird);
        if (e_drv) chk("d_rdata", d_rdata, e_drd);
    endtask

    task automatic step();
        bit ack, rd, lst, ei, ed;
        logic [31:0] data;
        if (rst) begin
            m_side = 0; m_n = 0; m_last = 2; m_we = 0;
            e_irv = 0; e_drv = 0; e_idn = 0; e_ddn = 0;
            e_ird = '0; e_drd = '0;
            return;
        end
        ack  = (m_side != 0) && mem_ack;
        rd   = ack && !m_we;
        lst  = ack && (m_n == LW - 1);
        data = {exp_addr(), 2'b00} ^ 32'h5A5A_0000;
        ei   = i_req && !e_idn;
        ed   = d_req && !e_ddn;
        e_irv = rd && m_side == 1;
        e_drv = rd && m_side == 2;
        if (e_irv) e_ird = data;
        if (e_drv) e_drd = data;
        e_idn = lst && m_side == 1;
        e_ddn = lst && m_side == 2;
        if (m_side != 0) begin
            if (ack) begin
                m_n++;
                if (m_n == LW) m_side = 0;
            end
        end else if (ei && (!ed || m_last == 2)) begin
            m_side = 1; m_n = 0; m_we = 0; m_last = 1;
            m_start = int'(i_addr % LW); m_line = i_addr - 30'(m_start);
            glog.push_back(1);
        end else if (ed) begin
            m_side = 2; m_n = 0; m_we = d_we; m_last = 2;
            m_start = int'(d_addr % LW); m_line = d_addr - 30'(m_start);
            glog.push_back(2);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rst     = rst_v;
        i_req   = i_pend;
        d_req   = d_pend;
        d_wdata = $urandom;
        if (ack_mode == 1) mem_ack = (cyc_n % 2 == 1);
        else if (ack_mode == 2 && m_side != 0 && m_n == 1 && stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
        end else mem_ack = 1'b1;
        #1;
        compare();
        if (mem_req) n_req++;
        if (mem_req && mem_ack) alog.push_back(mem_addr);
        if (d_wnext) begin n_wnext++; last_wn_c = cyc_n; end
        if (i_rvalid) begin n_irv++; last_irv_c = cyc_n; end
        if (d_rvalid) n_drv++;
        if (i_done) begin n_idone++; idone_c = cyc_n; olog.push_back(1); end
        if (d_done) begin n_ddone++; ddone_c = cyc_n; olog.push_back(2); end
        if (e_idn) i_pend = 0;
        if (e_ddn) d_pend = 0;
        step();
        cyc_n++;
    endtask

    task automatic drain(string name);
        int k;
        k = 0;
        while ((i_pend || d_pend || m_side != 0) && k < 200) begin
            cyc();
            k++;
        end
        checks++;
        if (k < 200) passes++;
        else $display("FAIL %s: timeout after %0d cycles", name, k);
        repeat (2) cyc();
    endtask

    task automatic do_reset();
        rst_v = 1; i_pend = 0; d_pend = 0;
        repeat (2) cyc();
        rst_v = 0;
        cyc();
    endtask

    initial begin
        logic [29:0] exp8[8];
        logic [29:0] got8[$];
        int k, dn8;
        clr();
        do_reset();
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);

        // 1: critical-word-first wrap on the I side
        clr(); ack_mode = 0;
        i_addr = 30'h0800_0002; i_pend = 1;
        drain("t1");
        chk("t1 beats", alog.size(), 4);
        if (alog.size() == 4) begin
            chk("t1 a0", alog[0], 30'h0800_0002);
            chk("t1 a1", alog[1], 30'h0800_0003);
            chk("t1 a2", alog[2], 30'h0800_0000);
            chk("t1 a3", alog[3], 30'h0800_0001);
        end
        chk("t1 irv", n_irv, 4);
        chk("t1 idone", n_idone, 1);
        chk("t1 done with last rvalid", idone_c, last_irv_c);

        // 2: simultaneous requests, round-robin from reset
        do_reset(); clr();
        i_addr = 30'h0000_0040; d_addr = 30'h0000_0200; d_we = 0;
        i_pend = 1; d_pend = 1;
        drain("t2a");
        i_pend = 1; d_pend = 1;
        drain("t2b");
        chk("t2 grants", glog.size(), 4);
        chk("t2 done order", olog.size(), 4);
        if (olog.size() == 4) begin
            chk("t2 o0", olog[0], 1);
            chk("t2 o1", olog[1], 2);
            chk("t2 o2", olog[2], 1);
            chk("t2 o3", olog[3], 2);
        end
        if (glog.size() == 4) chk("t2 model g2", glog[2], 1);

        // 3: D write-back with alternating acks
        clr(); ack_mode = 1;
        d_we = 1; d_addr = 30'h0000_0100; d_pend = 1;
        drain("t3");
        chk("t3 wnext", n_wnext, 4);
        chk("t3 drv", n_drv, 0);
        chk("t3 ddone", n_ddone, 1);
        chk("t3 done after ack", ddone_c, last_wn_c + 1);

        // 4: ten-cycle stall on the second beat
        clr(); ack_mode = 2; stall_left = 10;
        d_we = 0; i_addr = 30'h0123_4565; i_pend = 1;
        drain("t4");
        chk("t4 req cycles", n_req, 14);
        chk("t4 irv", n_irv, 4);
        chk("t4 idone", n_idone, 1);

        // 5: reset after the first beat of a D read
        clr(); ack_mode = 0;
        d_we = 0; d_addr = 30'h0000_0300; d_pend = 1;
        k = 0;
        while (!(m_side == 2 && m_n == 1) && k < 20) begin
            cyc();
            k++;
        end
        chk("t5 reached beat1", k < 20, 1);
        rst_v = 1; d_pend = 0;
        cyc();
        rst_v = 0;
        cyc();
        chk("t5 req after rst", mem_req, 0);
        i_addr = 30'h0000_0080; i_pend = 1;
        drain("t5");
        chk("t5 ddone", n_ddone, 0);
        chk("t5 idone", n_idone, 1);

        // 6: LINE_WORDS=8 wrap from offset 7
        exp8 = '{30'h0800_0007, 30'h0800_0000, 30'h0800_0001,
                 30'h0800_0002, 30'h0800_0003, 30'h0800_0004,
                 30'h0800_0005, 30'h0800_0006};
        dn8 = 0;
        i_addr8 = 30'h0800_0007;
        k = 0;
        while (dn8 == 0 && k < 40) begin
            @(negedge clk);
            i_req8 = 1'b1; ack8 = 1'b1;
            #1;
            if (mreq8 && ack8) got8.push_back(maddr8);
            if (i_dn8) dn8++;
            k++;
        end
        i_req8 = 1'b0;
        chk("t6 done", dn8, 1);
        chk("t6 beats", got8.size(), 8);
        for (int j = 0; j < 8; j++)
            if (j < got8.size()) chk("t6 addr", got8[j], exp8[j]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
